cube0414_frame_tx: RTL and testbench

CUBE0414_FRAME_TX -- requirements
Module: cube0414_frame_tx

---
 rtl/cube0414_pkg.sv | 29 ++
 rtl/cube0414_byte_ser.sv | 62 ++++++
 rtl/cube0414_frame_tx.sv | 163 ++++++++++++++++
 tb/tb_cube0414_frame_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cube0414_pkg.sv
// Shared constants, FSM state type and byte-select helpers for the cube frame transmitter.
// The ADDR_CMD/ADDR_DATA states exist only when CUBE0414_ADDR_PHASE_EN is defined.
package cube0414_pkg;

    localparam logic [7:0] CUBE0414_ADDR_WR = 8'hCC;
    localparam logic [7:0] CUBE0414_DATA_WR = 8'hDA;

    localparam logic [2:0] SelHi  = 3'b100;
    localparam logic [2:0] SelMid = 3'b010;
    localparam logic [2:0] SelLo  = 3'b001;

    typedef enum logic [2:0] {
        StIdle,
`ifdef CUBE0414_ADDR_PHASE_EN
        StAddrCmd,
        StAddrData,
`endif
        StDataCmd,
        StDataFetch,
        StDataWait,
        StDataByte,
        StDone
    } state_e;

    function automatic logic [2:0] rotate_sel(input logic [2:0] sel);
        return {sel[0], sel[2:1]};
    endfunction

endpackage

// File: rtl/cube0414_byte_ser.sv
// Pixel holding register with MSB-first byte select rotation and the valid/ready output stage.
// Command bytes bypass the holding register; pixel bytes come from the selected slice.
module cube0414_byte_ser
    import cube0414_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [23:0] i_data,
    input  logic        i_shift,
    input  logic        i_cmd_vld,
    input  logic        i_cmd_dc,
    input  logic [7:0]  i_cmd_byte,
    input  logic        i_data_vld,
    output logic        o_vld,
    output logic        o_dc,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [23:0] r_hold;
    logic [2:0]  r_sel;
    logic [7:0]  w_data_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= 24'h000000;
            r_sel  <= 3'b000;
        end else if (i_load) begin
            r_hold <= i_data;
            r_sel  <= SelHi;
        end else if (i_shift) begin
            r_sel  <= rotate_sel(r_sel);
        end
    end

    always_comb begin
        w_data_byte = 8'h00;
        unique case (r_sel)
            SelHi:   w_data_byte = r_hold[23:16];
            SelMid:  w_data_byte = r_hold[15:8];
            SelLo:   w_data_byte = r_hold[7:0];
            default: w_data_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_vld  = i_cmd_vld | i_data_vld;
        o_dc   = 1'b0;
        o_byte = 8'h00;
        if (i_data_vld) begin
            o_dc   = 1'b1;
            o_byte = w_data_byte;
        end else if (i_cmd_vld) begin
            o_dc   = i_cmd_dc;
            o_byte = i_cmd_byte;
        end
    end

    assign o_last = (r_sel == SelLo);

endmodule

// File: rtl/cube0414_frame_tx.sv
// Frame transmitter: optional address phase, then every layer/LED pixel as three data bytes.
// Address phase (CC + LED indices) is built only with CUBE0414_ADDR_PHASE_EN defined.
module cube0414_frame_tx
    import cube0414_pkg::*;
#(
    parameter int unsigned LAYER_NUM = 8,
    parameter int unsigned LED_NUM   = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        rd_en_out,
    output logic [8:0]  rd_addr_out,
    input  logic [23:0] rd_data_in,
    output logic        dc_out,
    output logic [7:0]  byte_out,
    output logic        byte_vld_out,
    input  logic        byte_rdy_in
);

    localparam logic [5:0] IdxLast   = 6'(LED_NUM - 1);
    localparam logic [2:0] LayerLast = 3'(LAYER_NUM - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [5:0] r_idx;
    logic [5:0] w_idx_nxt;
    logic [2:0] r_layer;
    logic [2:0] w_layer_nxt;

    logic       w_cmd_vld;
    logic       w_cmd_dc;
    logic [7:0] w_cmd_byte;
    logic       w_data_vld;
    logic       w_load;
    logic       w_shift;
    logic       w_last;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= StIdle;
            r_idx   <= 6'd0;
            r_layer <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_layer <= w_layer_nxt;
        end
    end

    // Offering states leave only on byte_rdy_in, so valid never retracts.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_layer_nxt = r_layer;
        w_cmd_vld   = 1'b0;
        w_cmd_dc    = 1'b0;
        w_cmd_byte  = 8'h00;
        w_data_vld  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        rd_en_out   = 1'b0;
        rd_addr_out = 9'h000;
        unique case (r_state)
            StIdle: begin
                if (start_in) begin
`ifdef CUBE0414_ADDR_PHASE_EN
                    w_state_nxt = StAddrCmd;
`else
                    w_state_nxt = StDataCmd;
`endif
                end
            end
`ifdef CUBE0414_ADDR_PHASE_EN
            StAddrCmd: begin
                w_cmd_vld  = 1'b1;
                w_cmd_byte = CUBE0414_ADDR_WR;
                if (byte_rdy_in) begin
                    w_state_nxt = StAddrData;
                    w_idx_nxt   = 6'd0;
                end
            end
            StAddrData: begin
                w_cmd_vld  = 1'b1;
                w_cmd_dc   = 1'b1;
                w_cmd_byte = {2'b00, r_idx};
                if (byte_rdy_in) begin
                    if (r_idx == IdxLast) begin
                        w_state_nxt = StDataCmd;
                        w_idx_nxt   = 6'd0;
                    end else begin
                        w_idx_nxt   = r_idx + 6'd1;
                    end
                end
            end
`endif
            StDataCmd: begin
                w_cmd_vld  = 1'b1;
                w_cmd_byte = CUBE0414_DATA_WR;
                if (byte_rdy_in) begin
                    w_state_nxt = StDataFetch;
                    w_layer_nxt = 3'd0;
                    w_idx_nxt   = 6'd0;
                end
            end
            StDataFetch: begin
                rd_en_out   = 1'b1;
                rd_addr_out = {r_layer, r_idx};
                w_state_nxt = StDataWait;
            end
            StDataWait: begin
                w_load      = 1'b1;
                w_state_nxt = StDataByte;
            end
            StDataByte: begin
                w_data_vld = 1'b1;
                w_shift    = byte_rdy_in;
                if (byte_rdy_in && w_last) begin
                    if (r_idx == IdxLast) begin
                        if (r_layer == LayerLast) begin
                            w_state_nxt = StDone;
                        end else begin
                            w_layer_nxt = r_layer + 3'd1;
                            w_idx_nxt   = 6'd0;
                            w_state_nxt = StDataFetch;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 6'd1;
                        w_state_nxt = StDataFetch;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign busy_out = (r_state != StIdle) && (r_state != StDone);
    assign done_out = (r_state == StDone);

    cube0414_byte_ser u_byte_ser (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_load     (w_load),
        .i_data     (rd_data_in),
        .i_shift    (w_shift),
        .i_cmd_vld  (w_cmd_vld),
        .i_cmd_dc   (w_cmd_dc),
        .i_cmd_byte (w_cmd_byte),
        .i_data_vld (w_data_vld),
        .o_vld      (byte_vld_out),
        .o_dc       (dc_out),
        .o_byte     (byte_out),
        .o_last     (w_last)
    );

endmodule

// File: tb/tb_cube0414_frame_tx.sv
// Randomized bench for cube0414_frame_tx: default-size and 2x4 instances against a queue model.
// Follows CUBE0414_ADDR_PHASE_EN so the expected frame matches the build.
module tb_cube0414_frame_tx;

    localparam int L0 = 8;
    localparam int N0 = 64;
    localparam int L1 = 2;
    localparam int N1 = 4;
    localparam int Budget = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic d_start = 1'b0;
    logic s_start = 1'b0;

    logic        d_busy, d_done, d_rd_en, d_dc, d_vld;
    logic [8:0]  d_addr;
    logic [7:0]  d_byte;
    logic [23:0] d_rd_data = 24'h0;
    logic        s_busy, s_done, s_rd_en, s_dc, s_vld;
    logic [8:0]  s_addr;
    logic [7:0]  s_byte;
    logic [23:0] s_rd_data = 24'h0;

    always #5 clk = ~clk;

    cube0414_frame_tx #(.LAYER_NUM(L0), .LED_NUM(N0)) u_dut (
        .clk_in(clk), .rst_in(rst), .start_in(d_start), .busy_out(d_busy), .done_out(d_done),
        .rd_en_out(d_rd_en), .rd_addr_out(d_addr), .rd_data_in(d_rd_data), .dc_out(d_dc),
        .byte_out(d_byte), .byte_vld_out(d_vld), .byte_rdy_in(rdy)
    );

    cube0414_frame_tx #(.LAYER_NUM(L1), .LED_NUM(N1)) u_dut_small (
        .clk_in(clk), .rst_in(rst), .start_in(s_start), .busy_out(s_busy), .done_out(s_done),
        .rd_en_out(s_rd_en), .rd_addr_out(s_addr), .rd_data_in(s_rd_data), .dc_out(s_dc),
        .byte_out(s_byte), .byte_vld_out(s_vld), .byte_rdy_in(rdy)
    );

    logic [23:0] mem [512];

    always @(posedge clk) begin
        if (d_rd_en) d_rd_data <= mem[d_addr];
        if (s_rd_en) s_rd_data <= mem[s_addr];
    end

    bit          sel = 1'b0;
    logic        m_busy, m_done, m_rd_en, m_dc, m_vld;
    logic [8:0]  m_addr;
    logic [7:0]  m_byte;
    assign m_busy  = sel ? s_busy  : d_busy;
    assign m_done  = sel ? s_done  : d_done;
    assign m_rd_en = sel ? s_rd_en : d_rd_en;
    assign m_dc    = sel ? s_dc    : d_dc;
    assign m_vld   = sel ? s_vld   : d_vld;
    assign m_addr  = sel ? s_addr  : d_addr;
    assign m_byte  = sel ? s_byte  : d_byte;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [8:0] exp_q [$];
    logic [8:0] exp_a [$];
    int got_n, mism, addr_n, amism, dones, viol, busy_cyc;
    bit         prev_hold;
    logic [8:0] prev_val;

    // Sampled mid-cycle: values shown here are the ones seen at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if ((prev_hold && (!m_vld || {m_dc, m_byte} != prev_val)) || (m_vld && m_rd_en))
                viol <= viol + 1;
            prev_hold <= m_vld && !rdy;
            prev_val  <= {m_dc, m_byte};
            if (m_vld && rdy) begin
                if (got_n >= exp_q.size() || exp_q[got_n] != {m_dc, m_byte}) mism <= mism + 1;
                got_n <= got_n + 1;
            end
            if (m_rd_en) begin
                if (addr_n >= exp_a.size() || exp_a[addr_n] != m_addr) amism <= amism + 1;
                addr_n <= addr_n + 1;
            end
            if (m_done) dones <= dones + 1;
            if (m_busy) busy_cyc <= busy_cyc + 1;
        end
    end

    function automatic int frame_len(input int l, input int n);
`ifdef CUBE0414_ADDR_PHASE_EN
        return 2 + n + 3 * l * n;
`else
        return 1 + 3 * l * n;
`endif
    endfunction

    task automatic build_exp(input int l, input int n);
        logic [23:0] w;
        int a;
        exp_q.delete();
        exp_a.delete();
`ifdef CUBE0414_ADDR_PHASE_EN
        exp_q.push_back({1'b0, 8'hCC});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 8'(i)});
`endif
        exp_q.push_back({1'b0, 8'hDA});
        for (int ly = 0; ly < l; ly++) begin
            for (int i = 0; i < n; i++) begin
                a = ly * 64 + i;
                w = mem[a];
                exp_a.push_back(9'(a));
                exp_q.push_back({1'b1, w[23:16]});
                exp_q.push_back({1'b1, w[15:8]});
                exp_q.push_back({1'b1, w[7:0]});
            end
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) s_start = v;
        else d_start = v;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_done"}, 32'(m_done), 0);
        check({tag, "_rd_en"}, 32'(m_rd_en), 0);
        check({tag, "_vld"}, 32'(m_vld), 0);
        check({tag, "_dc"}, 32'(m_dc), 0);
        check({tag, "_byte"}, 32'(m_byte), 0);
        check({tag, "_addr"}, 32'(m_addr), 0);
    endtask

    task automatic run_frame(input string tag, input int l, input int n, input int pct,
                             input bit pulse, input int abort_at, output bit aborted);
        int cyc;
        build_exp(l, n);
        got_n = 0; mism = 0; addr_n = 0; amism = 0; dones = 0; viol = 0; busy_cyc = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        set_start(1'b1);
        rdy = ($urandom_range(0, 99) < pct);
        @(posedge clk); #1;
        set_start(1'b0);
        cyc = 0;
        while (dones == 0 && cyc < Budget) begin
            rdy = ($urandom_range(0, 99) < pct);
            if (pulse) set_start($urandom_range(0, 7) == 0);
            if (abort_at > 0 && got_n >= abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        set_start(1'b0);
        if (!aborted) check({tag, "_in_time"}, 32'(cyc < Budget), 1);
    endtask

    task automatic frame_checks(input string tag, input int l, input int n, input bit chk_busy);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_len"}, 32'(got_n), 32'(frame_len(l, n)));
        check({tag, "_seq_mism"}, 32'(mism), 0);
        check({tag, "_reads"}, 32'(addr_n), 32'(l * n));
        check({tag, "_addr_mism"}, 32'(amism), 0);
        check({tag, "_done_cnt"}, 32'(dones), 1);
        check({tag, "_handshake"}, 32'(viol), 0);
        check({tag, "_idle_busy"}, 32'(m_busy), 0);
        if (chk_busy) check({tag, "_busy_cyc"}, 32'(busy_cyc), 32'(frame_len(l, n) + 2 * l * n));
    endtask

    initial begin
        bit ab;
        for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        run_frame("full_rdy1", L0, N0, 100, 1'b0, 0, ab);
        frame_checks("full_rdy1", L0, N0, 1'b1);

        run_frame("full_rdy50", L0, N0, 50, 1'b0, 0, ab);
        frame_checks("full_rdy50", L0, N0, 1'b0);

        run_frame("abort", L0, N0, 50, 1'b0, 700, ab);
        check("abort_hit", 32'(ab), 1);
        @(posedge clk); #1;
        check_quiet("abort_rst");
        check("abort_no_done", 32'(dones), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(m_busy), 0);

        run_frame("after_abort", L0, N0, 50, 1'b0, 0, ab);
        frame_checks("after_abort", L0, N0, 1'b0);

        run_frame("start_busy", L0, N0, 70, 1'b1, 0, ab);
        frame_checks("start_busy", L0, N0, 1'b0);

        sel = 1'b1;
        run_frame("small", L1, N1, 100, 1'b0, 0, ab);
        frame_checks("small", L1, N1, 1'b1);

        run_frame("small_rdy50", L1, N1, 50, 1'b1, 0, ab);
        frame_checks("small_rdy50", L1, N1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
